// File: rtl/sha_nonce_scheduler.sv
// Nonce scheduler for an array of SHA-256 cores. It hands out nonces to free cores,
// captures each h0 result and serialises the results onto one memory write port.
module sha_nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES*32-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*32-1:0] core_h0,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2} state_t;

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [8:0] LAST = 9'(NUM_NONCES);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [8:0]             r_next_nonce;
  logic [8:0]             r_write_count;
  logic [15:0]            r_base;
  logic [NUM_CORES-1:0]   r_busy;
  logic [NUM_CORES-1:0]   r_pending;
  logic [31:0]            r_res_h0 [NUM_CORES];
  logic [7:0]             r_core_nonce [NUM_CORES];
  logic                   r_mem_we;
  logic [15:0]            r_mem_addr;
  logic [31:0]            r_mem_data;
  logic [CW-1:0]          r_wr_core;

  logic [NUM_CORES-1:0]   w_freeing;
  logic [NUM_CORES-1:0]   w_capture;
  logic [NUM_CORES-1:0]   w_pend_all;
  logic [NUM_CORES-1:0]   w_wr_onehot;
  logic [NUM_CORES-1:0]   w_disp_onehot;
  logic                   w_write;
  logic [CW-1:0]          w_wr_core;
  logic [31:0]            w_wr_h0;
  logic [7:0]             w_wr_nonce;
  logic                   w_dispatch;
  logic                   w_free_any;
  logic [CW-1:0]          w_disp_core;

  // Core handshake: core_start is a one-cycle request; the core answers with a one-cycle
  // core_done carrying core_h0. A core stays busy until its result has left on mem_we.
  always_comb begin
    w_state_nxt   = r_state;
    w_freeing     = '0;
    w_capture     = '0;
    w_pend_all    = '0;
    w_write       = 1'b0;
    w_wr_core     = '0;
    w_wr_onehot   = '0;
    w_wr_h0       = '0;
    w_wr_nonce    = '0;
    w_dispatch    = 1'b0;
    w_free_any    = 1'b0;
    w_disp_core   = '0;
    w_disp_onehot = '0;
    core_start    = '0;
    core_nonce    = '0;

    for (int k = 0; k < NUM_CORES; k++) begin
      w_freeing[k] = r_mem_we && (r_wr_core == CW'(k));
    end

    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // A core whose result is on the port this cycle must not be captured again.
        w_capture  = core_done & r_busy & ~r_pending & ~w_freeing;
        w_pend_all = r_pending | w_capture;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
          if (w_pend_all[k]) begin
            w_write    = 1'b1;
            w_wr_core  = CW'(k);
            w_wr_h0    = w_capture[k] ? core_h0[k*32 +: 32] : r_res_h0[k];
            w_wr_nonce = r_core_nonce[k];
          end
          if (!r_busy[k]) begin
            w_free_any  = 1'b1;
            w_disp_core = CW'(k);
          end
        end
        w_dispatch = w_free_any && (r_next_nonce < LAST);
        if (r_write_count == LAST) w_state_nxt = S_FINISH;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    for (int k = 0; k < NUM_CORES; k++) begin
      w_wr_onehot[k]       = w_write && (w_wr_core == CW'(k));
      w_disp_onehot[k]     = w_dispatch && (w_disp_core == CW'(k));
      core_start[k]        = w_disp_onehot[k] && !reset;
      core_nonce[k*32 +: 32] = w_disp_onehot[k] ? {24'd0, r_next_nonce[7:0]}
                                                : {24'd0, r_core_nonce[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_next_nonce  <= '0;
      r_write_count <= '0;
      r_base        <= '0;
      r_busy        <= '0;
      r_pending     <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_wr_core     <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        r_res_h0[k]     <= '0;
        r_core_nonce[k] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_mem_we  <= w_write;
      r_pending <= (r_pending | w_capture) & ~w_wr_onehot;
      r_busy    <= (r_busy & ~w_freeing) | w_disp_onehot;
      if (w_write) begin
        r_mem_addr    <= r_base + {8'd0, w_wr_nonce};
        r_mem_data    <= w_wr_h0;
        r_wr_core     <= w_wr_core;
        r_write_count <= r_write_count + 9'd1;
      end
      if (w_dispatch) r_next_nonce <= r_next_nonce + 9'd1;
      for (int k = 0; k < NUM_CORES; k++) begin
        if (w_capture[k])     r_res_h0[k]     <= core_h0[k*32 +: 32];
        if (w_disp_onehot[k]) r_core_nonce[k] <= r_next_nonce[7:0];
      end
      if (r_state == S_IDLE && start) begin
        r_base        <= output_addr;
        r_next_nonce  <= '0;
        r_write_count <= '0;
        r_busy        <= '0;
        r_pending     <= '0;
      end
    end
  end

  assign done           = (r_state == S_IDLE);
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_data;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Bench for sha_nonce_scheduler: a 4-core/16-nonce instance and a 1-core/2-nonce instance,
// driven by behavioural cores with programmable latency and checked through a write scoreboard.
module tb_sha_nonce_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  output_addr;
  logic         done;
  logic [3:0]   core_start;
  logic [127:0] core_nonce;
  logic [3:0]   core_done;
  logic [127:0] core_h0;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic [1:0]   dbg_state;

  logic         start1;
  logic [15:0]  addr1;
  logic         done1;
  logic [0:0]   cs1;
  logic [31:0]  cn1;
  logic [0:0]   cd1;
  logic [31:0]  ch1;
  logic         we1;
  logic [15:0]  ma1;
  logic [31:0]  md1;
  logic [1:0]   st1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [47:0] exp_q[$];
  logic [47:0] exp1_q[$];
  logic [15:0] cur_base;
  logic [15:0] base1;
  int exp_nonce = 0;
  int wr_cnt = 0;
  int disp_core[16];
  int disp_cyc[16];
  int wr_cyc[16];
  logic [15:0] wr_addr[16];
  int d1_cnt = 0;
  int w1_cnt = 0;
  int disp1_cyc[4];
  int w1_cyc[4];
  int lat_tab[4];
  int ref_span = 0;

  sha_nonce_scheduler #(.NUM_CORES(4), .NUM_NONCES(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .output_addr(output_addr), .done(done),
    .core_start(core_start), .core_nonce(core_nonce), .core_done(core_done), .core_h0(core_h0),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data), .dbg_state(dbg_state)
  );

  sha_nonce_scheduler #(.NUM_CORES(1), .NUM_NONCES(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .output_addr(addr1), .done(done1),
    .core_start(cs1), .core_nonce(cn1), .core_done(cd1), .core_h0(ch1),
    .mem_we(we1), .mem_addr(ma1), .mem_write_data(md1), .dbg_state(st1)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hfun(input logic [31:0] n);
    return 32'hA000_0000 + n;
  endfunction

  // Behavioural cores: done pulses lat cycles after the start pulse, h0 random otherwise
  initial begin
    int rem[4];
    logic [31:0] nn[4];
    int rem1;
    logic [31:0] nn1;
    for (int k = 0; k < 4; k++) begin
      rem[k] = 0;
      nn[k] = '0;
      lat_tab[k] = 10;
    end
    rem1 = 0;
    nn1 = '0;
    core_done = '0;
    core_h0 = '0;
    cd1 = '0;
    ch1 = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        core_done[k] = 1'b0;
        core_h0[k*32 +: 32] = $urandom();
        if (rem[k] > 0) begin
          rem[k]--;
          if (rem[k] == 0) begin
            core_done[k] = 1'b1;
            core_h0[k*32 +: 32] = hfun(nn[k]);
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (core_start[k]) begin
          rem[k] = lat_tab[k];
          nn[k] = core_nonce[k*32 +: 32];
        end
      end
      cd1 = 1'b0;
      ch1 = $urandom();
      if (rem1 > 0) begin
        rem1--;
        if (rem1 == 0) begin
          cd1 = 1'b1;
          ch1 = hfun(nn1);
        end
      end
      if (cs1[0]) begin
        rem1 = 5;
        nn1 = cn1;
      end
    end
  end

  // Scoreboard: expected write pushed at dispatch, popped on mem_we
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (core_start != 4'b0000) begin
        n_cmp++;
        if ($countones(core_start) != 1) begin
          n_bad++;
          $display("FAIL multi_start: got %b required one-hot", core_start);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (core_start[k]) begin
          n_cmp++;
          if (core_nonce[k*32 +: 32] !== 32'(exp_nonce)) begin
            n_bad++;
            $display("FAIL dispatch_nonce core %0d: got %0d required %0d", k, core_nonce[k*32 +: 32], exp_nonce);
          end
          if (exp_nonce < 16) begin
            disp_core[exp_nonce] = k;
            disp_cyc[exp_nonce] = cyc;
          end
          exp_q.push_back({cur_base + 16'(exp_nonce), hfun(32'(exp_nonce))});
          exp_nonce++;
        end
      end
      if (mem_we) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr %h data %h required no write", mem_addr, mem_write_data);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_write_data} !== e) begin
            n_bad++;
            $display("FAIL write: got %h/%h required %h/%h", mem_addr, mem_write_data, e[47:32], e[31:0]);
          end
        end
        if (wr_cnt < 16) begin
          wr_cyc[wr_cnt] = cyc;
          wr_addr[wr_cnt] = mem_addr;
        end
        wr_cnt++;
      end
      if (cs1[0]) begin
        n_cmp++;
        if (cn1 !== 32'(d1_cnt)) begin
          n_bad++;
          $display("FAIL dispatch_nonce_1c: got %0d required %0d", cn1, d1_cnt);
        end
        if (d1_cnt < 4) disp1_cyc[d1_cnt] = cyc;
        exp1_q.push_back({base1 + 16'(d1_cnt), hfun(32'(d1_cnt))});
        d1_cnt++;
      end
      if (we1) begin
        n_cmp++;
        if (exp1_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write_1c: got addr %h data %h required no write", ma1, md1);
        end else begin
          e = exp1_q.pop_front();
          if ({ma1, md1} !== e) begin
            n_bad++;
            $display("FAIL write_1c: got %h/%h required %h/%h", ma1, md1, e[47:32], e[31:0]);
          end
        end
        if (w1_cnt < 4) w1_cyc[w1_cnt] = cyc;
        w1_cnt++;
      end
    end
  end

  // Driver: launch one run on the 4-core instance and wait for done
  task automatic do_run(input logic [15:0] base, input bit glitch, output bit timed_out, output int st_cyc);
    cur_base = base;
    exp_nonce = 0;
    wr_cnt = 0;
    exp_q.delete();
    @(posedge clk); #1;
    output_addr = base;
    start = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    output_addr = 16'($urandom_range(0, 65535));
    timed_out = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      start = glitch && (i == 15 || i == 30);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    output_addr = 16'h0;
    addr1 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, core_start, core_nonce, mem_we, mem_addr, mem_write_data, dbg_state} !==
        {1'b1, 4'b0, 128'b0, 1'b0, 16'h0, 32'h0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_4c: got done=%b cs=%b we=%b addr=%h data=%h st=%0d required idle zeros",
               done, core_start, mem_we, mem_addr, mem_write_data, dbg_state);
    end
    n_cmp++;
    if ({done1, cs1, cn1, we1, ma1, md1, st1} !== {1'b1, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_1c: got done=%b cs=%b we=%b addr=%h data=%h required idle zeros",
               done1, cs1, we1, ma1, md1);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b1 || done1 !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_after_reset: got done=%b done1=%b required 1 1", done, done1);
    end
  endtask

  task automatic test_single_core();
    int st_cyc;
    int rise_cyc;
    bit to;
    base1 = 16'h0100;
    d1_cnt = 0;
    w1_cnt = 0;
    exp1_q.delete();
    @(posedge clk); #1;
    addr1 = 16'h0100;
    start1 = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    start1 = 1'b0;
    addr1 = 16'h7777;
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL done_fall_1c: got %b required 0", done1);
    end
    to = 1'b1;
    rise_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done1) begin
        to = 1'b0;
        rise_cyc = cyc;
        break;
      end
    end
    n_cmp++;
    if (to || d1_cnt != 2 || w1_cnt != 2 || exp1_q.size() != 0) begin
      n_bad++;
      $display("FAIL run_1c: got timeout=%0d dispatches=%0d writes=%0d left=%0d required 0 2 2 0",
               to, d1_cnt, w1_cnt, exp1_q.size());
    end else begin
      n_cmp++;
      if (disp1_cyc[0] != st_cyc + 1) begin
        n_bad++;
        $display("FAIL first_dispatch_1c: got cycle %0d required %0d", disp1_cyc[0], st_cyc + 1);
      end
      n_cmp++;
      if (w1_cyc[0] != disp1_cyc[0] + 6) begin
        n_bad++;
        $display("FAIL write_latency_1c: got cycle %0d required %0d", w1_cyc[0], disp1_cyc[0] + 6);
      end
      n_cmp++;
      if (disp1_cyc[1] != w1_cyc[0] + 1) begin
        n_bad++;
        $display("FAIL redispatch_1c: got cycle %0d required %0d", disp1_cyc[1], w1_cyc[0] + 1);
      end
      n_cmp++;
      if (rise_cyc != w1_cyc[1] + 2) begin
        n_bad++;
        $display("FAIL done_rise_1c: got cycle %0d required %0d", rise_cyc, w1_cyc[1] + 2);
      end
    end
  endtask

  task automatic test_dispatch_order();
    bit to;
    int st_cyc;
    for (int k = 0; k < 4; k++) lat_tab[k] = 10;
    do_run(16'h1000, 1'b0, to, st_cyc);
    n_cmp++;
    if (to || wr_cnt != 16 || exp_nonce != 16 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL run_4c: got timeout=%0d writes=%0d dispatches=%0d left=%0d required 0 16 16 0",
               to, wr_cnt, exp_nonce, exp_q.size());
    end else begin
      n_cmp++;
      if (disp_cyc[0] != st_cyc + 1) begin
        n_bad++;
        $display("FAIL first_dispatch: got cycle %0d required %0d", disp_cyc[0], st_cyc + 1);
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (disp_core[k] != k || disp_cyc[k] != disp_cyc[0] + k) begin
          n_bad++;
          $display("FAIL dispatch_order nonce %0d: got core %0d cycle %0d required core %0d cycle %0d",
                   k, disp_core[k], disp_cyc[k], k, disp_cyc[0] + k);
        end
      end
      n_cmp++;
      if (wr_cyc[0] != disp_cyc[0] + 11) begin
        n_bad++;
        $display("FAIL write_latency: got cycle %0d required %0d", wr_cyc[0], disp_cyc[0] + 11);
      end
      ref_span = wr_cyc[15] - disp_cyc[0];
    end
  endtask

  task automatic test_simultaneous_done();
    bit to;
    int st_cyc;
    for (int k = 0; k < 4; k++) lat_tab[k] = 10 - k;
    do_run(16'h4000, 1'b0, to, st_cyc);
    n_cmp++;
    if (to || wr_cnt != 16 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL run_simul: got timeout=%0d writes=%0d left=%0d required 0 16 0", to, wr_cnt, exp_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (wr_cyc[k] != disp_cyc[0] + 11 + k) begin
          n_bad++;
          $display("FAIL simul_write %0d: got cycle %0d required %0d", k, wr_cyc[k], disp_cyc[0] + 11 + k);
        end
      end
      n_cmp++;
      if (disp_core[4] != 0 || disp_cyc[4] != wr_cyc[0] + 1) begin
        n_bad++;
        $display("FAIL simul_redispatch: got core %0d cycle %0d required core 0 cycle %0d",
                 disp_core[4], disp_cyc[4], wr_cyc[0] + 1);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    int st_cyc;
    for (int k = 0; k < 4; k++) lat_tab[k] = 10;
    do_run(16'h2000, 1'b1, to, st_cyc);
    n_cmp++;
    if (to || wr_cnt != 16 || exp_nonce != 16 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL start_ignored: got timeout=%0d writes=%0d dispatches=%0d left=%0d required 0 16 16 0",
               to, wr_cnt, exp_nonce, exp_q.size());
    end else begin
      n_cmp++;
      if (wr_cyc[15] - disp_cyc[0] != ref_span) begin
        n_bad++;
        $display("FAIL start_ignored_timing: got span %0d required %0d", wr_cyc[15] - disp_cyc[0], ref_span);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    int st_cyc;
    int stale;
    for (int k = 0; k < 4; k++) lat_tab[k] = 10;
    cur_base = 16'h0200;
    exp_nonce = 0;
    wr_cnt = 0;
    exp_q.delete();
    @(posedge clk); #1;
    output_addr = 16'h0200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_nonce == 3) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL reset_mid_setup: got %0d dispatches required 3", exp_nonce);
    end
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({done, mem_we, core_start, core_nonce, dbg_state} !== {1'b1, 1'b0, 4'b0, 128'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_mid_run: got done=%b we=%b cs=%b st=%0d required 1 0 0000 0",
               done, mem_we, core_start, dbg_state);
    end
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_we) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_bad++;
      $display("FAIL stale_done: got %0d writes required 0", stale);
    end
    do_run(16'h0300, 1'b0, to, st_cyc);
    n_cmp++;
    if (to || wr_cnt != 16 || exp_q.size() != 0 || disp_core[0] != 0 || disp_cyc[0] != st_cyc + 1) begin
      n_bad++;
      $display("FAIL restart: got timeout=%0d writes=%0d left=%0d core0=%0d required 0 16 0 0",
               to, wr_cnt, exp_q.size(), disp_core[0]);
    end
  endtask

  task automatic test_addr_wrap();
    bit to;
    int st_cyc;
    int lat;
    logic [15:0] want[4];
    want[0] = 16'hFFFE;
    want[1] = 16'hFFFF;
    want[2] = 16'h0000;
    want[3] = 16'h0001;
    lat = $urandom_range(3, 12);
    for (int k = 0; k < 4; k++) lat_tab[k] = lat;
    do_run(16'hFFFE, 1'b0, to, st_cyc);
    n_cmp++;
    if (to || wr_cnt != 16 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL run_wrap: got timeout=%0d writes=%0d left=%0d required 0 16 0", to, wr_cnt, exp_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (wr_addr[k] !== want[k]) begin
          n_bad++;
          $display("FAIL addr_wrap %0d: got %h required %h", k, wr_addr[k], want[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_dispatch_order();
    test_simultaneous_done();
    test_start_ignored();
    test_reset_mid_run();
    test_addr_wrap();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
